// File: rtl/rgb_frame_capture_if.sv
// Purpose: bundles the pixel-in stream, the capture control and the frame-buffer
//          write port of rgb_frame_capture into one interface.
// Ports:   slave = capture block side (pixels/start in, write port/status out);
//          master = the side driving pixels and observing the write port.
interface rgb_frame_capture_if #(
   parameter int ADDR_W = 19
);
   logic [7:0]        red_i;
   logic [7:0]        green_i;
   logic [7:0]        blue_i;
   logic              done_i;
   logic              start_i;
   logic              wr_en_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [23:0]       wr_data_o;
   logic              busy_o;
   logic              frame_done_o;
   logic              ovf_o;
   logic [15:0]       col_o;
   logic [15:0]       row_o;
   logic [15:0]       checksum_o;

   modport slave (
      input  red_i, green_i, blue_i, done_i, start_i,
      output wr_en_o, wr_addr_o, wr_data_o, busy_o, frame_done_o,
             ovf_o, col_o, row_o, checksum_o
   );

   modport master (
      output red_i, green_i, blue_i, done_i, start_i,
      input  wr_en_o, wr_addr_o, wr_data_o, busy_o, frame_done_o,
             ovf_o, col_o, row_o, checksum_o
   );
endinterface

// File: rtl/rgb_frame_capture.sv
// Purpose: captures exactly one raster frame of RGB pixels into an external frame
//          buffer after a start pulse, then pulses frame_done_o; 1-cycle write latency.
// Ports:   sys_clk_i / sys_rst_i (async, active-low) plus px_if (slave modport):
//          pixel stream + start in, write port + busy/done/ovf/col/row/checksum out.
//          No backpressure: pixels outside a capture are dropped and flagged on ovf_o.
//          Optional running checksum enabled by defining CAPTURE_CHECKSUM_EN.
module rgb_frame_capture #(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int ADDR_W = 19
) (
   input  logic                 sys_clk_i,
   input  logic                 sys_rst_i,
   rgb_frame_capture_if.slave   px_if
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   localparam logic [15:0] COL_LAST = 16'(IMG_W - 1);
   localparam logic [15:0] ROW_LAST = 16'(IMG_H - 1);

   state_t            r_state;
   state_t            w_next;

   logic [15:0]       r_col;
   logic [15:0]       r_row;
   logic [ADDR_W-1:0] r_addr;

   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [23:0]       r_wr_data;
   logic [15:0]       r_col_out;
   logic [15:0]       r_row_out;
   logic              r_ovf;

   logic              w_accept;
   logic              w_last;
   logic              w_start;
   logic              w_drop;
   logic              w_busy;
   logic              w_frame_done;

   assign w_accept = (r_state == S_CAPTURE) && px_if.done_i;
   assign w_last   = w_accept && (r_col == COL_LAST) && (r_row == ROW_LAST);
   assign w_start  = (r_state == S_IDLE) && px_if.start_i;
   // Any pixel arriving outside CAPTURE is lost, including one coincident with start.
   assign w_drop   = px_if.done_i && (r_state != S_CAPTURE);

   // FSM: state register
   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) r_state <= S_IDLE;
      else            r_state <= w_next;
   end

   // FSM: next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (px_if.start_i) w_next = S_CAPTURE;
         S_CAPTURE: if (w_last)        w_next = S_DONE;
         S_DONE:                       w_next = S_IDLE;
         default:                      w_next = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      w_busy       = 1'b0;
      w_frame_done = 1'b0;
      case (r_state)
         S_CAPTURE: w_busy       = 1'b1;
         S_DONE:    w_frame_done = 1'b1;
         default:   ;
      endcase
   end

   // Raster position and linear address advance together; no multiply needed.
   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         r_col  <= '0;
         r_row  <= '0;
         r_addr <= '0;
      end else if (w_start) begin
         r_col  <= '0;
         r_row  <= '0;
         r_addr <= '0;
      end else if (w_accept) begin
         r_addr <= r_addr + ADDR_W'(1);
         if (r_col == COL_LAST) begin
            r_col <= '0;
            r_row <= (r_row == ROW_LAST) ? 16'd0 : r_row + 16'd1;
         end else begin
            r_col <= r_col + 16'd1;
         end
      end
   end

   // Registered write port; address/data/position hold between writes.
   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_col_out <= '0;
         r_row_out <= '0;
      end else begin
         r_wr_en <= w_accept;
         if (w_accept) begin
            r_wr_addr <= r_addr;
            r_wr_data <= {px_if.red_i, px_if.green_i, px_if.blue_i};
            r_col_out <= r_col;
            r_row_out <= r_row;
         end
      end
   end

   // Sticky overflow: a dropped pixel wins over the clear from an accepted start.
   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i)   r_ovf <= 1'b0;
      else if (w_drop)  r_ovf <= 1'b1;
      else if (w_start) r_ovf <= 1'b0;
   end

`ifdef CAPTURE_CHECKSUM_EN
   logic [15:0] r_checksum;

   always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
      if (!sys_rst_i)
         r_checksum <= '0;
      else if (w_start)
         r_checksum <= '0;
      else if (w_accept)
         r_checksum <= r_checksum + 16'(px_if.red_i) + 16'(px_if.green_i)
                                  + 16'(px_if.blue_i);
   end

   assign px_if.checksum_o = r_checksum;
`else
   assign px_if.checksum_o = 16'd0;
`endif

   assign px_if.wr_en_o      = r_wr_en;
   assign px_if.wr_addr_o    = r_wr_addr;
   assign px_if.wr_data_o    = r_wr_data;
   assign px_if.busy_o       = w_busy;
   assign px_if.frame_done_o = w_frame_done;
   assign px_if.ovf_o        = r_ovf;
   assign px_if.col_o        = r_col_out;
   assign px_if.row_o        = r_row_out;

endmodule

// File: tb/tb_rgb_frame_capture.sv
// Purpose: self-checking bench for rgb_frame_capture on a 4x2 frame; directed
//          scenarios followed by randomized frames, checked against a frame-level model.
// Ports:   none (top-level bench); drives the DUT through rgb_frame_capture_if.
module tb_rgb_frame_capture;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int AW = 3;

   logic sys_clk_i = 1'b0;
   logic sys_rst_i = 1'b0;
   always #5 sys_clk_i = ~sys_clk_i;

   rgb_frame_capture_if #(.ADDR_W(AW)) px_if ();

   rgb_frame_capture #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .sys_clk_i (sys_clk_i),
      .sys_rst_i (sys_rst_i),
      .px_if     (px_if)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_wr     = 0;
   int n_fd     = 0;

   // Reference model: a frame is W*H pixels indexed 0..W*H-1 in raster order.
   bit          m_busy;
   bit          m_fd;
   bit          m_ovf;
   int          m_cnt;
   logic [2:0]  m_addr;
   logic [23:0] m_data;
   bit          m_wr;
   logic [15:0] m_col, m_row, m_sum;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_fd = 0; m_ovf = 0; m_cnt = 0; m_wr = 0;
      m_addr = '0; m_data = '0; m_col = '0; m_row = '0; m_sum = '0;
   endtask

   task automatic model_step(input bit st, input bit dv, input logic [7:0] r,
                             input logic [7:0] g, input logic [7:0] b);
      bit was_done;
      was_done = m_fd;
      m_fd = 0;
      m_wr = 0;
      if (m_busy) begin
         if (dv) begin
            m_wr   = 1;
            m_addr = AW'(m_cnt);
            m_data = {r, g, b};
            m_col  = 16'(m_cnt % W);
            m_row  = 16'(m_cnt / W);
            m_sum  = m_sum + 16'(r) + 16'(g) + 16'(b);
            m_cnt++;
            if (m_cnt == W * H) begin
               m_busy = 0;
               m_fd   = 1;
            end
         end
      end else begin
         if (st && !was_done) begin
            m_busy = 1; m_cnt = 0; m_sum = '0; m_ovf = 0;
         end
         if (dv) m_ovf = 1;
      end
   endtask

   task automatic check_all();
      chk("wr_en",      32'(px_if.wr_en_o),      32'(m_wr));
      chk("wr_addr",    32'(px_if.wr_addr_o),    32'(m_addr));
      chk("wr_data",    32'(px_if.wr_data_o),    32'(m_data));
      chk("busy",       32'(px_if.busy_o),       32'(m_busy));
      chk("frame_done", 32'(px_if.frame_done_o), 32'(m_fd));
      chk("ovf",        32'(px_if.ovf_o),        32'(m_ovf));
      chk("col",        32'(px_if.col_o),        32'(m_col));
      chk("row",        32'(px_if.row_o),        32'(m_row));
`ifdef CAPTURE_CHECKSUM_EN
      chk("checksum",   32'(px_if.checksum_o),   32'(m_sum));
`else
      chk("checksum",   32'(px_if.checksum_o),   32'd0);
`endif
   endtask

   task automatic cyc(input bit st, input bit dv, input logic [7:0] r,
                      input logic [7:0] g, input logic [7:0] b);
      px_if.start_i = st;
      px_if.done_i  = dv;
      px_if.red_i   = r;
      px_if.green_i = g;
      px_if.blue_i  = b;
      model_step(st, dv, r, g, b);
      @(posedge sys_clk_i);
      #1;
      check_all();
      if (px_if.wr_en_o === 1'b1)      n_wr++;
      if (px_if.frame_done_o === 1'b1) n_fd++;
   endtask

   task automatic idle();
      cyc(0, 0, 8'd0, 8'd0, 8'd0);
   endtask

   task automatic px(input int k);
      cyc(0, 1, 8'(k), 8'(k), 8'(k));
   endtask

   task automatic frame_k();
      cyc(1, 0, 8'd0, 8'd0, 8'd0);
      for (int k = 1; k <= 8; k++) px(k);
   endtask

   initial begin
      px_if.start_i = 0; px_if.done_i = 0;
      px_if.red_i = 0; px_if.green_i = 0; px_if.blue_i = 0;
      model_reset();
      repeat (2) @(posedge sys_clk_i);
      #1;
      check_all();
      sys_rst_i = 1'b1;
      idle();

      // Basic frame of (k,k,k).
      n_wr = 0; n_fd = 0;
      frame_k();
      idle(); idle();
      chk("f1_writes", 32'(n_wr), 32'd8);
      chk("f1_done_pulses", 32'(n_fd), 32'd1);
`ifdef CAPTURE_CHECKSUM_EN
      chk("f1_checksum", 32'(px_if.checksum_o), 32'd108);
`endif

      // Gap of 3 cycles after pixel 4; position holds at (3,0).
      n_wr = 0;
      cyc(1, 0, 8'd0, 8'd0, 8'd0);
      for (int k = 1; k <= 4; k++) px(k);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("gap_col", 32'(px_if.col_o), 32'd3);
         chk("gap_row", 32'(px_if.row_o), 32'd0);
      end
      for (int k = 5; k <= 8; k++) px(k);
      idle();
      chk("gap_writes", 32'(n_wr), 32'd8);

      // Pixels in IDLE set ovf; start alone clears it.
      n_wr = 0;
      px(9); px(10);
      chk("idle_no_write", 32'(n_wr), 32'd0);
      chk("idle_ovf", 32'(px_if.ovf_o), 32'd1);
      cyc(1, 0, 8'd0, 8'd0, 8'd0);
      chk("start_clears_ovf", 32'(px_if.ovf_o), 32'd0);

      // start mid-capture is ignored.
      n_fd = 0;
      for (int k = 1; k <= 3; k++) px(k);
      cyc(1, 0, 8'd0, 8'd0, 8'd0);
      cyc(1, 1, 8'd4, 8'd4, 8'd4);
      for (int k = 5; k <= 8; k++) px(k);
      idle();
      chk("midstart_done_pulses", 32'(n_fd), 32'd1);

      // start and pixel together in IDLE: ovf ends set.
      cyc(1, 1, 8'd7, 8'd7, 8'd7);
      chk("start_drop_ovf", 32'(px_if.ovf_o), 32'd1);

      // Asynchronous reset after pixel 5.
      for (int k = 1; k <= 5; k++) px(k);
      #3;
      sys_rst_i = 1'b0;
      model_reset();
      #1;
      check_all();
      px_if.done_i = 0; px_if.start_i = 0;
      @(posedge sys_clk_i);
      #1;
      check_all();
      sys_rst_i = 1'b1;
      idle();
      n_wr = 0; n_fd = 0;
      frame_k();
      idle();
      chk("post_reset_writes", 32'(n_wr), 32'd8);
      chk("post_reset_done", 32'(n_fd), 32'd1);

      // Back-to-back: start in DONE ignored, start in following IDLE honoured.
      n_fd = 0;
      cyc(1, 0, 8'd0, 8'd0, 8'd0);
      for (int k = 1; k <= 8; k++) px(k);
      cyc(1, 0, 8'd0, 8'd0, 8'd0);
      chk("done_start_ignored", 32'(px_if.busy_o), 32'd0);
      frame_k();
      idle();
      chk("b2b_done_pulses", 32'(n_fd), 32'd2);

      // Randomized frames with gaps, noise starts and stray pixels.
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 3; i++)
            cyc(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
         cyc(1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
         for (int i = 0; i < 30; i++)
            cyc(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0),
                8'($urandom), 8'($urandom), 8'($urandom));
         idle(); idle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rgb_frame_capture.md
# rgb_frame_capture

Frame capture sink for the pixel stream leaving the Sobel pipeline. Accepts one RGB pixel per cycle when `done_i` is high, in raster order, and writes each pixel into an external frame buffer via a simple synchronous write port. Arms on a start pulse, captures exactly one frame, then signals completion. Sits directly downstream of `sobel_top` and consumes its `red_o`/`green_o`/`blue_o`/`done_o`.

## Interface
- `IMG_W`, 640, pixels per line (≥2)
- `IMG_H`, 480, lines per frame (≥1)
- `ADDR_W`, 19, write-address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H
- `sys_clk_i`  in  1  system clock, all logic on rising edge
- `sys_rst_i`  in  1  asynchronous reset, active-low
- `red_i`  in  8  pixel red component
- `green_i`  in  8  pixel green component
- `blue_i`  in  8  pixel blue component
- `done_i`  in  1  pixel-valid strobe; one pixel per high cycle
- `start_i`  in  1  arm capture of next frame (single-cycle pulse)
- `wr_en_o`  out  1  frame-buffer write enable
- `wr_addr_o`  out  ADDR_W  frame-buffer write address
- `wr_data_o`  out  24  write data `{red, green, blue}`
- `busy_o`  out  1  high while in CAPTURE
- `frame_done_o`  out  1  one-cycle pulse on last pixel written
- `ovf_o`  out  1  sticky: pixel arrived while not capturing
- `col_o`  out  16  column of the last written pixel
- `row_o`  out  16  row of the last written pixel
- `checksum_o`  out  16  frame checksum (see Configuration)

## Operation
- States: IDLE, CAPTURE, DONE. Reset state IDLE.
- IDLE: `start_i`=1 → CAPTURE; clears column/row/address counters, checksum and `ovf_o`.
- CAPTURE: each `done_i`=1 cycle registers `{red_i,green_i,blue_i}` to `wr_data_o`, current address to `wr_addr_o`, current col/row to `col_o`/`row_o`, and asserts `wr_en_o` next cycle.
- Address counter increments by 1 per accepted pixel (no multiply). Column wraps IMG_W-1 → 0 with row increment.
- Accepting pixel at col=IMG_W-1, row=IMG_H-1 → DONE.
- DONE: lasts one cycle, then IDLE unconditionally.
- `done_i`=1 in IDLE or DONE: pixel dropped, no write, `ovf_o` set to 1 and held until next accepted `start_i`.
- `start_i` in CAPTURE or DONE: ignored.
- `start_i` and `done_i` together in IDLE: start accepted, pixel dropped, `ovf_o` ends at 1 (set wins over clear).
- Gaps in `done_i` during CAPTURE are legal; counters hold.

## Timing
- Reset values: `wr_en_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `busy_o`=0, `frame_done_o`=0, `ovf_o`=0, `col_o`=0, `row_o`=0, `checksum_o`=0.
- Latency: `done_i` high in cycle N → `wr_en_o` high in N+1 with that pixel's address/data. `wr_en_o` is a one-cycle pulse per pixel.
- `busy_o` rises the cycle after `start_i` and falls the cycle after the last pixel is accepted.
- `frame_done_o` high in the same cycle as the final `wr_en_o` (the cycle the FSM is in DONE).
- Back-to-back frames: a `start_i` is first honoured the cycle after DONE (IDLE); minimum one idle cycle between frames.
- Reset asserted mid-frame: all state and outputs return to reset values immediately; no partial `frame_done_o`.

## Configuration
- `CAPTURE_CHECKSUM_EN` defined: 16-bit running sum (modulo 2^16) of `red+green+blue` for each accepted pixel, cleared on accepted `start_i`; `checksum_o` updates with each write and holds its final value from `frame_done_o` until the next accepted `start_i`.
- Not defined: no accumulator logic; `checksum_o` constant 0.

## Test plan
- IMG_W=4, IMG_H=2; `start_i`, then 8 consecutive pixels with RGB=(k,k,k), k=1..8 → 8 writes, addr 0..7, data 0x010101..0x080808, `frame_done_o` with addr 7, `busy_o` low afterwards; with macro `checksum_o`=108.
- Same frame with `done_i` deasserted for 3 cycles after pixel 4 → identical write sequence, no extra writes, `col_o`/`row_o` hold at (3,0) during gap.
- `done_i` pulses in IDLE with no `start_i` → no `wr_en_o`, `ovf_o`=1; subsequent `start_i` alone → `ovf_o`=0.
- `start_i` pulse in mid-CAPTURE after pixel 3 → ignored; addresses continue 3..7, single `frame_done_o`.
- Reset asserted after pixel 5 → all outputs 0 asynchronously; new `start_i` and full frame → writes start again at addr 0.
- Two frames with `start_i` in the IDLE cycle following DONE → second frame writes addr 0..7, two `frame_done_o` pulses total.
